// File: rtl/sargantana_icache_ifill_mshr_pkg.sv
// sargantana_icache_pkg: shared types and helpers for the icache instruction-fill MSHR
//   Holds the default sizes, the MSHR entry and pointer types, and the functions
//   that extract and compare line addresses.
//   Ports: none (package).
package sargantana_icache_pkg;

   localparam int ICACHE_NUM_ENTRIES   = 4;
   localparam int ICACHE_PADDR_SIZE    = 40;
   localparam int ICACHE_LINE_OFF_BITS = 4;
   localparam int ICACHE_DATA_W        = 128;
   localparam int ICACHE_LINE_W        = ICACHE_PADDR_SIZE - ICACHE_LINE_OFF_BITS;
   localparam int ICACHE_PTR_W         = $clog2(ICACHE_NUM_ENTRIES);

   typedef logic [ICACHE_LINE_W-1:0] line_addr_t;

   // One extra MSB so that equal indices with different wrap bits mean full
   typedef logic [ICACHE_PTR_W:0] mshr_ptr_t;

   typedef struct packed {
      logic       valid;
      logic       sent;
      logic       killed;
      line_addr_t line;
   } mshr_entry_t;

   function automatic line_addr_t line_of(input logic [ICACHE_PADDR_SIZE-1:0] paddr);
      return paddr[ICACHE_PADDR_SIZE-1:ICACHE_LINE_OFF_BITS];
   endfunction

   function automatic logic line_match(input line_addr_t a, input line_addr_t b);
      return a == b;
   endfunction

endpackage

// File: rtl/sargantana_icache_ifill_mshr_if.sv
// sargantana_icache_ifill_mshr_if: miss, fill, invalidate and refill signals of the ifill MSHR
//   master: icache / upper-level side (drives misses, fill responses, invalidates)
//   slave : the MSHR itself
interface sargantana_icache_ifill_mshr_if
   import sargantana_icache_pkg::*;
#(
   parameter int PADDR_SIZE = ICACHE_PADDR_SIZE,
   parameter int DATA_W     = ICACHE_DATA_W
) ();

   logic                  flush;
   logic                  miss_valid;
   logic [PADDR_SIZE-1:0] miss_paddr;
   logic                  miss_ready;
   logic                  miss_merged;
   logic                  ifill_req_valid;
   logic [PADDR_SIZE-1:0] ifill_req_paddr;
   logic                  ifill_req_ready;
   logic                  ifill_resp_valid;
   logic                  ifill_resp_ack;
   logic [DATA_W-1:0]     ifill_resp_data;
   logic                  inv_valid;
   logic [PADDR_SIZE-1:0] inv_paddr;
   logic                  refill_valid;
   logic [PADDR_SIZE-1:0] refill_paddr;
   logic [DATA_W-1:0]     refill_data;
   logic                  resp_err;
   logic                  busy;

   modport master (
      output flush, miss_valid, miss_paddr, ifill_req_ready, ifill_resp_valid, ifill_resp_ack,
             ifill_resp_data, inv_valid, inv_paddr,
      input  miss_ready, miss_merged, ifill_req_valid, ifill_req_paddr, refill_valid,
             refill_paddr, refill_data, resp_err, busy
   );

   modport slave (
      input  flush, miss_valid, miss_paddr, ifill_req_ready, ifill_resp_valid, ifill_resp_ack,
             ifill_resp_data, inv_valid, inv_paddr,
      output miss_ready, miss_merged, ifill_req_valid, ifill_req_paddr, refill_valid,
             refill_paddr, refill_data, resp_err, busy
   );

endinterface

// File: rtl/sargantana_icache_line_match.sv
// sargantana_icache_line_match: compares one line address against every MSHR entry in parallel
//   addr    in  line address to look up
//   entries in  MSHR entries
//   hit     out one bit per entry: entry valid and its line equals addr
module sargantana_icache_line_match
   import sargantana_icache_pkg::*;
#(
   parameter int N = ICACHE_NUM_ENTRIES
) (
   input  line_addr_t   addr,
   input  mshr_entry_t  entries [N],
   output logic [N-1:0] hit
);

   always_comb begin
      hit = '0;
      for (int i = 0; i < N; i++) hit[i] = entries[i].valid & line_match(addr, entries[i].line);
   end

endmodule

// File: rtl/sargantana_icache_ifill_mshr.sv
// sargantana_icache_ifill_mshr: in-order multi-outstanding instruction-fill miss buffer
//   clk_i, rstn_i   clock, async active-low reset
//   bus (slave)     miss accept/merge, fill request, fill response, invalidate, refill, status
//   Optional macro ICACHE_MSHR_PMU_EN adds pmu_merge_o, pmu_full_o, pmu_kill_drop_o.
module sargantana_icache_ifill_mshr
   import sargantana_icache_pkg::*;
#(
   parameter int NUM_ENTRIES   = ICACHE_NUM_ENTRIES,
   parameter int PADDR_SIZE    = ICACHE_PADDR_SIZE,
   parameter int LINE_OFF_BITS = ICACHE_LINE_OFF_BITS,
   parameter int DATA_W        = ICACHE_DATA_W
) (
   input logic                          clk_i,
   input logic                          rstn_i,
   sargantana_icache_ifill_mshr_if.slave bus
`ifdef ICACHE_MSHR_PMU_EN
   ,
   output logic                         pmu_merge_o,
   output logic                         pmu_full_o,
   output logic                         pmu_kill_drop_o
`endif
);

   localparam int PTR_W = $clog2(NUM_ENTRIES);

   mshr_entry_t            ent [NUM_ENTRIES];
   mshr_ptr_t              rd_ptr, wr_ptr, iss_ptr;
   logic                   resp_err;
   logic [NUM_ENTRIES-1:0] merge_raw, inv_raw, inv_act, merge_hit, valid_vec, killed_vec;
   logic [PTR_W-1:0]       rd_idx, wr_idx, iss_idx;
   mshr_entry_t            head, iss_e;
   logic                   full, accept, merged, push, req_valid, req_fire, iss_skip;
   logic                   resp, head_ok, inv_head, pop_resp, pop_drop, pop, refill;

   sargantana_icache_line_match #(.N(NUM_ENTRIES)) u_merge_match (
      .addr   (line_of(bus.miss_paddr)),
      .entries(ent),
      .hit    (merge_raw)
   );

   sargantana_icache_line_match #(.N(NUM_ENTRIES)) u_inv_match (
      .addr   (line_of(bus.inv_paddr)),
      .entries(ent),
      .hit    (inv_raw)
   );

   always_comb begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         valid_vec[i]  = ent[i].valid;
         killed_vec[i] = ent[i].killed;
      end
      rd_idx    = rd_ptr[PTR_W-1:0];
      wr_idx    = wr_ptr[PTR_W-1:0];
      iss_idx   = iss_ptr[PTR_W-1:0];
      head      = ent[rd_idx];
      iss_e     = ent[iss_idx];
      full      = (rd_ptr[PTR_W] != wr_ptr[PTR_W]) && (rd_idx == wr_idx);
      inv_act   = bus.inv_valid ? inv_raw : '0;
      // An entry being invalidated this cycle cannot absorb a new miss: its data would be stale
      merge_hit = merge_raw & ~killed_vec & ~inv_act;
      bus.miss_ready  = rstn_i & ~full & ~bus.flush;
      accept    = bus.miss_valid & bus.miss_ready;
      merged    = accept & |merge_hit;
      push      = accept & ~|merge_hit;
      req_valid = iss_e.valid & ~iss_e.sent & ~iss_e.killed;
      req_fire  = req_valid & bus.ifill_req_ready;
      iss_skip  = iss_e.valid & ~iss_e.sent & iss_e.killed;
      resp      = bus.ifill_resp_valid & bus.ifill_resp_ack;
      head_ok   = head.valid & head.sent;
      inv_head  = inv_act[rd_idx];
      pop_resp  = resp & head_ok;
      pop_drop  = head.valid & head.killed & ~head.sent;
      pop       = pop_resp | pop_drop;
      refill    = pop_resp & ~head.killed & ~inv_head;
      bus.miss_merged     = merged;
      bus.ifill_req_valid = req_valid;
      bus.ifill_req_paddr = req_valid ? PADDR_SIZE'({iss_e.line, {LINE_OFF_BITS{1'b0}}}) : '0;
      bus.refill_valid    = refill;
      bus.refill_paddr    = refill ? PADDR_SIZE'({head.line, {LINE_OFF_BITS{1'b0}}}) : '0;
      bus.refill_data     = refill ? bus.ifill_resp_data : DATA_W'(0);
      bus.resp_err        = resp_err;
      bus.busy            = |valid_vec;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < NUM_ENTRIES; i++) ent[i] <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         iss_ptr  <= '0;
         resp_err <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++)
            if (ent[i].valid && (bus.flush || inv_act[i])) ent[i].killed <= 1'b1;
         if (req_fire) ent[iss_idx].sent <= 1'b1;
         if (pop) ent[rd_idx].valid <= 1'b0;
         if (push) ent[wr_idx] <= '{valid: 1'b1, sent: 1'b0, killed: 1'b0, line: line_of(bus.miss_paddr)};
         rd_ptr   <= rd_ptr + {{PTR_W{1'b0}}, pop};
         wr_ptr   <= wr_ptr + {{PTR_W{1'b0}}, push};
         iss_ptr  <= iss_ptr + {{PTR_W{1'b0}}, req_fire | iss_skip};
         resp_err <= resp_err | (resp & ~head_ok);
      end
   end

`ifdef ICACHE_MSHR_PMU_EN
   assign pmu_merge_o     = merged;
   assign pmu_full_o      = bus.miss_valid & full;
   assign pmu_kill_drop_o = pop & (head.killed | inv_head);
`endif

endmodule

// File: tb/tb_sargantana_icache_ifill_mshr.sv
// tb_sargantana_icache_ifill_mshr: directed bench with request/refill scoreboards
module tb_sargantana_icache_ifill_mshr;
   import sargantana_icache_pkg::*;

   typedef struct {
      logic         v;
      logic [39:0]  pa;
      logic [127:0] d;
   } refill_t;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   int           n_cmp = 0;
   int           n_err = 0;
   int           n_req = 0;
   int           req_base;
   logic [39:0]  req_q [$];
   refill_t      exp_q [$];
   refill_t      e;

   sargantana_icache_ifill_mshr_if bus ();

`ifdef ICACHE_MSHR_PMU_EN
   logic pmu_merge, pmu_full, pmu_kill_drop;
`endif

   sargantana_icache_ifill_mshr dut (
      .clk_i (clk),
      .rstn_i(rstn),
      .bus   (bus)
`ifdef ICACHE_MSHR_PMU_EN
      ,
      .pmu_merge_o    (pmu_merge),
      .pmu_full_o     (pmu_full),
      .pmu_kill_drop_o(pmu_kill_drop)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      bus.miss_valid       = 1'b0;
      bus.ifill_resp_valid = 1'b0;
      bus.ifill_resp_ack   = 1'b0;
      bus.inv_valid        = 1'b0;
      bus.flush            = 1'b0;
   endtask

   task automatic miss(input logic [39:0] pa, input logic fresh);
      cyc();
      bus.miss_valid = 1'b1;
      bus.miss_paddr = pa;
      if (fresh) req_q.push_back({pa[39:4], 4'h0});
      @(negedge clk);
   endtask

   task automatic ack(input logic [127:0] d, input logic v, input logic [39:0] pa, input logic inv);
      cyc();
      bus.ifill_resp_valid = 1'b1;
      bus.ifill_resp_ack   = 1'b1;
      bus.ifill_resp_data  = d;
      bus.inv_valid        = inv;
      bus.inv_paddr        = pa;
      exp_q.push_back('{v, pa, d});
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (rstn) begin
         if (bus.ifill_req_valid && bus.ifill_req_ready) begin
            n_req++;
            n_cmp++;
            assert (req_q.size() > 0) else begin
               n_err++;
               $error("FAIL req_unexpected: observed request %0h, expected none", bus.ifill_req_paddr);
            end
            if (req_q.size() > 0) chk("req_paddr", bus.ifill_req_paddr, req_q.pop_front());
         end
         if (bus.ifill_resp_valid && bus.ifill_resp_ack) begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("refill_valid", bus.refill_valid, e.v);
               if (e.v) begin
                  chk("refill_paddr", bus.refill_paddr, e.pa);
                  chk("refill_data", bus.refill_data, e.d);
               end
            end
         end else begin
            chk("refill_spurious", bus.refill_valid, 0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, expected finish before timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.flush = 0; bus.miss_valid = 0; bus.miss_paddr = '0; bus.ifill_req_ready = 0;
      bus.ifill_resp_valid = 0; bus.ifill_resp_ack = 0; bus.ifill_resp_data = '0;
      bus.inv_valid = 0; bus.inv_paddr = '0;
      @(negedge clk);
      chk("rst_miss_ready", bus.miss_ready, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_req_valid", bus.ifill_req_valid, 0);
      chk("rst_refill_valid", bus.refill_valid, 0);
      chk("rst_resp_err", bus.resp_err, 0);
      @(posedge clk);
      #1 rstn = 1'b1;
      bus.ifill_req_ready = 1'b1;

      // single miss, fill, refill
      miss(40'h1000, 1);
      chk("a_accept", bus.miss_ready, 1);
      chk("a_merged", bus.miss_merged, 0);
      idle(1);
      chk("a_req_latency", bus.ifill_req_valid, 1);
      ack({16{8'hA5}}, 1, 40'h1000, 0);
      idle(1);
      chk("a_busy_idle", bus.busy, 0);

      // duplicate line merges
      req_base = n_req;
      miss(40'h1000, 1);
      chk("b_first_merged", bus.miss_merged, 0);
      miss(40'h1008, 0);
      chk("b_second_merged", bus.miss_merged, 1);
      chk("b_second_ready", bus.miss_ready, 1);
      idle(1);
      ack({16{8'h3C}}, 1, 40'h1000, 0);
      idle(1);
      chk("b_one_request", n_req - req_base, 1);
      chk("b_busy_idle", bus.busy, 0);

      // fill FIFO, fifth miss stalls until first pop, no same-cycle bypass
      bus.ifill_req_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         miss(40'h3000 + 40'(k * 16), 1);
         chk("c_accept", bus.miss_ready, 1);
      end
      for (int k = 0; k < 7; k++) begin
         cyc();
         bus.ifill_req_ready = (k >= 3);
         bus.miss_valid = 1'b1;
         bus.miss_paddr = 40'h3040;
         @(negedge clk);
         chk("c_full_hold", bus.miss_ready, 0);
         if (k < 3) chk("c_req_stable", bus.ifill_req_paddr, 40'h3000);
      end
      cyc();
      bus.miss_valid = 1'b1;
      bus.miss_paddr = 40'h3040;
      bus.ifill_resp_valid = 1'b1;
      bus.ifill_resp_ack = 1'b1;
      bus.ifill_resp_data = 128'h3000;
      exp_q.push_back('{1'b1, 40'h3000, 128'h3000});
      @(negedge clk);
      chk("c_no_bypass", bus.miss_ready, 0);
      miss(40'h3040, 1);
      chk("c_fifth_accept", bus.miss_ready, 1);
      chk("c_fifth_merged", bus.miss_merged, 0);
      for (int k = 1; k < 5; k++) ack(128'(k) << 64, 1, 40'h3000 + 40'(k * 16), 0);
      idle(1);
      chk("c_busy_idle", bus.busy, 0);

      // flush with two sent and two unsent entries
      miss(40'h4000, 1);
      miss(40'h4010, 1);
      miss(40'h4020, 0);
      cyc();
      bus.ifill_req_ready = 1'b0;
      bus.miss_valid = 1'b1;
      bus.miss_paddr = 40'h4030;
      @(negedge clk);
      chk("d_fourth_accept", bus.miss_ready, 1);
      cyc();
      bus.flush = 1'b1;
      @(negedge clk);
      chk("d_flush_ready", bus.miss_ready, 0);
      cyc();
      bus.ifill_req_ready = 1'b1;
      @(negedge clk);
      chk("d_no_req_after_flush", bus.ifill_req_valid, 0);
      ack({16{8'h11}}, 0, 40'h4000, 0);
      ack({16{8'h22}}, 0, 40'h4010, 0);
      idle(1);
      chk("d_busy_dropping", bus.busy, 1);
      idle(2);
      chk("d_busy_idle", bus.busy, 0);

      // invalidate hitting the head in the ack cycle
      miss(40'h2000, 1);
      idle(1);
      ack({16{8'h5A}}, 0, 40'h2000, 1);
      idle(1);
      chk("e_busy_idle", bus.busy, 0);
      chk("e_resp_err", bus.resp_err, 0);

      // ack with empty FIFO
      ack({16{8'hEE}}, 0, 40'h0, 0);
      idle(1);
      chk("f_resp_err_set", bus.resp_err, 1);
      idle(3);
      chk("f_resp_err_sticky", bus.resp_err, 1);

      chk("req_queue_drained", req_q.size(), 0);
      chk("refill_queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
